// File: rtl/trig_cal_pkg.sv
// trig_cal_pkg: shared FSM state type and saturating counter helper for the trigger phase calibrator
package trig_cal_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, WINDOW, EVAL, WAIT} cal_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trig_phase_hist.sv
// trig_phase_hist: one channel's saturating phase-bin histogram with argmax and lock evaluation
module trig_phase_hist
    import trig_cal_pkg::*;
#(
    parameter int NPHASE = 4,
    parameter int CW = 8,
    localparam int B = $clog2(NPHASE)
) (
    input  logic          clk_adc,
    input  logic          nrst,
    input  logic          clr,
    input  logic          hit,
    input  logic [B-1:0]  phase,
    input  logic [B-1:0]  rd_ph,
    input  logic [CW-1:0] expect_cnt,
    input  logic [CW-1:0] tol,
    output logic [CW-1:0] rd_val,
    output logic [B-1:0]  best,
    output logic          lk
);

    localparam logic [CW-1:0] CMAX = '1;

    logic [CW-1:0] cnt [NPHASE];
    logic [CW-1:0] mx, lo, hi;
    logic [CW:0]   lo_w, hi_w;
    logic          clean;

    // bin counters: cleared at the start of each run, saturate instead of wrapping
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            for (int p = 0; p < NPHASE; p++) cnt[p] <= '0;
        end else if (clr) begin
            for (int p = 0; p < NPHASE; p++) cnt[p] <= '0;
        end else if (hit) begin
            cnt[phase] <= CW'(sat_inc(32'(cnt[phase]), 32'(CMAX)));
        end
    end

    assign rd_val = cnt[rd_ph];

    // lowest-index maximum bin; lock needs a single populated bin inside the clamped tolerance band
    always_comb begin
        best  = '0;
        mx    = cnt[0];
        clean = 1'b1;
        for (int p = 1; p < NPHASE; p++) begin
            if (cnt[p] > mx) begin
                mx   = cnt[p];
                best = B'(p);
            end
        end
        for (int p = 0; p < NPHASE; p++) begin
            if (B'(p) != best && cnt[p] != '0) clean = 1'b0;
        end
        lo_w = {1'b0, expect_cnt} - {1'b0, tol};
        hi_w = {1'b0, expect_cnt} + {1'b0, tol};
        lo   = lo_w[CW] ? '0 : lo_w[CW-1:0];
        hi   = hi_w[CW] ? CMAX : hi_w[CW-1:0];
        lk   = clean && (mx >= lo) && (mx <= hi);
    end

endmodule

// File: rtl/trig_phase_cal.sv
// trig_phase_cal: drives a calibration window and histograms returning trigger channels per phase bin
module trig_phase_cal
    import trig_cal_pkg::*;
#(
    parameter int NCH = 16,
    parameter int NPHASE = 4,
    parameter int CW = 8,
    parameter int PW = 28,
    localparam int B = $clog2(NPHASE),
    localparam int CB = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_adc,
    input  logic           nrst,
    input  logic [NCH-1:0] coax_in,
    input  logic           start,
    input  logic           continuous,
    input  logic [PW-1:0]  window_len,
    input  logic [PW-1:0]  period_len,
    input  logic [CW-1:0]  expect_cnt,
    input  logic [CW-1:0]  tol,
    input  logic [CB-1:0]  rd_ch,
    input  logic [B-1:0]   rd_ph,
    output logic [CW-1:0]  rd_data,
    output logic           cal_pulse,
    output logic [B-1:0]   phase,
    output logic           busy,
    output logic           done,
    output logic [NCH-1:0] lock,
    output logic [NCH*B-1:0] best_phase
);

    cal_state_e    state_q, state_d;
    logic [NCH-1:0] sync1, sync2;
    logic [PW:0]   pcnt, wl_last, per_min, per_eff;
    logic [PW-1:0] wl_eff;
    logic [CB-1:0] ecnt;
    logic [CW-1:0] rd_v [NCH];
    logic [B-1:0]  best_v [NCH];
    logic [NCH-1:0] lk_v;

    assign wl_eff  = (window_len == '0) ? PW'(1) : window_len;
    assign wl_last = {1'b0, wl_eff} - 1'b1;
    assign per_min = {1'b0, wl_eff} + (PW+1)'(NCH + 2);
    assign per_eff = ({1'b0, period_len} < per_min) ? per_min : {1'b0, period_len};

    // state register
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else state_q <= state_d;
    end

    // next state and window/status outputs; period counter is 0 on the first window cycle,
    // so leaving WAIT at per_eff-2 puts consecutive window starts exactly per_eff apart
    always_comb begin
        state_d   = state_q;
        cal_pulse = 1'b0;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = CLEAR;
            CLEAR:  state_d = WINDOW;
            WINDOW: begin
                cal_pulse = 1'b1;
                if (pcnt == wl_last) state_d = EVAL;
            end
            EVAL: begin
                if (ecnt == CB'(NCH - 1)) begin
                    done    = 1'b1;
                    state_d = continuous ? WAIT : IDLE;
                end
            end
            WAIT: begin
                if (!continuous) state_d = IDLE;
                else if (pcnt >= per_eff - 2'd2) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
    end

    // free-running phase, input synchronisers, window/period and eval-slot counters
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            phase <= '0;
            sync1 <= '0;
            sync2 <= '0;
            pcnt  <= '0;
            ecnt  <= '0;
        end else begin
            phase <= phase + 1'b1;
            sync1 <= coax_in;
            sync2 <= sync1;
            pcnt  <= (state_q == CLEAR) ? '0 : pcnt + 1'b1;
            ecnt  <= (state_q == EVAL) ? ecnt + 1'b1 : '0;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        trig_phase_hist #(.NPHASE(NPHASE), .CW(CW)) u_hist (
            .clk_adc   (clk_adc),
            .nrst      (nrst),
            .clr       (state_q == CLEAR),
            .hit       (sync2[c] && state_q == WINDOW),
            .phase     (phase),
            .rd_ph     (rd_ph),
            .expect_cnt(expect_cnt),
            .tol       (tol),
            .rd_val    (rd_v[c]),
            .best      (best_v[c]),
            .lk        (lk_v[c])
        );
    end

    // latch one channel's evaluation per EVAL cycle; results persist until re-evaluated
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) begin
            lock       <= '0;
            best_phase <= '0;
        end else if (state_q == EVAL) begin
            lock[ecnt]                     <= lk_v[ecnt];
            best_phase[int'(ecnt)*B +: B]  <= best_v[ecnt];
        end
    end

    // registered histogram read port
    always_ff @(posedge clk_adc or negedge nrst) begin
        if (!nrst) rd_data <= '0;
        else rd_data <= rd_v[rd_ch];
    end

endmodule

// File: tb/tb_trig_phase_cal.sv
// tb_trig_phase_cal: directed self-checking bench for the trigger phase calibrator
module tb_trig_phase_cal;

    localparam int NCH = 16, NPHASE = 4, CW = 8, PW = 28;

    logic            clk_adc = 1'b0;
    logic            nrst = 1'b0;
    logic [NCH-1:0]  coax_in = '0;
    logic            start = 1'b0;
    logic            continuous = 1'b0;
    logic [PW-1:0]   window_len = '0;
    logic [PW-1:0]   period_len = '0;
    logic [CW-1:0]   expect_cnt = '0;
    logic [CW-1:0]   tol = '0;
    logic [3:0]      rd_ch = '0;
    logic [1:0]      rd_ph = '0;
    logic [CW-1:0]   rd_data;
    logic            cal_pulse;
    logic [1:0]      phase;
    logic            busy;
    logic            done;
    logic [NCH-1:0]  lock;
    logic [NCH*2-1:0] best_phase;

    int checks = 0;
    int errors = 0;
    logic [1:0] ph_model;
    logic pulse0 = 1'b0, hold3 = 1'b0, hold5 = 1'b0;

    trig_phase_cal #(.NCH(NCH), .NPHASE(NPHASE), .CW(CW), .PW(PW)) dut (
        .clk_adc   (clk_adc),
        .nrst      (nrst),
        .coax_in   (coax_in),
        .start     (start),
        .continuous(continuous),
        .window_len(window_len),
        .period_len(period_len),
        .expect_cnt(expect_cnt),
        .tol       (tol),
        .rd_ch     (rd_ch),
        .rd_ph     (rd_ph),
        .rd_data   (rd_data),
        .cal_pulse (cal_pulse),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .lock      (lock),
        .best_phase(best_phase)
    );

    always #5 clk_adc = ~clk_adc;

    // reference phase: free-running modulo 4 from reset
    always @(posedge clk_adc or negedge nrst) begin
        if (!nrst) ph_model <= '0;
        else ph_model <= ph_model + 2'd1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock; inputs change and outputs are sampled 1 time unit after the edge.
    // ch0 is driven when phase==0 so its synchronised sample lands in bin 2.
    task automatic cyc();
        @(posedge clk_adc);
        #1;
        coax_in[0] = pulse0 && (ph_model == 2'd0);
        coax_in[3] = hold3;
        coax_in[5] = hold5;
    endtask

    task automatic rd(input int ch, input int ph, output int v);
        rd_ch = 4'(ch);
        rd_ph = 2'(ph);
        cyc();
        v = int'(rd_data);
    endtask

    // single-shot run: done must appear wl+1+NCH cycles after start is sampled
    task automatic launch(input int wl, input string tag);
        int n;
        start = 1'b1;
        cyc();
        n = 1;
        start = 1'b0;
        while (done !== 1'b1 && n < wl + 200) begin
            cyc();
            n++;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_done_time"}, n, wl + 17);
        cyc();
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    int v, p0, a, b, exp_b, n, rises, dones;
    int rise_t[4];
    logic prev;
    int wl_t[4]  = '{248, 252, 8, 1100};
    int ex_t[4]  = '{60, 60, 1, 250};
    int tol_t[4] = '{2, 2, 5, 10};
    int lk_t[4]  = '{1, 0, 1, 1};
    int cnt_t[4] = '{62, 63, 2, 255};

    initial begin
        repeat (3) cyc();
        chk("rst_cal_pulse", cal_pulse, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lock", lock, 0);
        chk("rst_best", best_phase, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_phase", phase, 0);
        nrst = 1'b1;
        repeat (5) cyc();
        chk("phase_run", phase, ph_model);

        // single shot, ch0 hitting bin 2 only
        window_len = 250; expect_cnt = 62; tol = 1; pulse0 = 1'b1;
        repeat (4) cyc();
        launch(250, "ss");
        chk("ss_lock0", lock[0], 1);
        chk("ss_best0", best_phase[1:0], 2);
        chk("ss_lock_others", lock[15:1], 0);
        chk("ss_best1", best_phase[3:2], 0);
        chk("ss_done_low", done, 0);
        rd(0, 2, v); chk("ss_cnt0_2_range", (v == 62 || v == 63), 1);
        rd(0, 0, v); chk("ss_cnt0_0", v, 0);
        rd(0, 3, v); chk("ss_cnt0_3", v, 0);

        // ch3 held high: first two window phases get 63, tie -> lowest index
        pulse0 = 1'b0; hold3 = 1'b1;
        repeat (4) cyc();
        p0 = int'(ph_model);
        a = (p0 + 2) % 4;
        b = (p0 + 3) % 4;
        exp_b = (a < b) ? a : b;
        launch(250, "hold");
        chk("hold_lock3", lock[3], 0);
        chk("hold_best3", best_phase[7:6], exp_b);
        chk("hold_lock0_reeval", lock[0], 0);
        rd(3, exp_b, v); chk("hold_cnt_max", v, 63);
        rd(3, p0 % 4, v); chk("hold_cnt_low", v, 62);

        // saturation
        hold3 = 1'b0; hold5 = 1'b1;
        repeat (4) cyc();
        window_len = 2000;
        launch(2000, "sat");
        for (int p = 0; p < 4; p++) begin
            rd(5, p, v);
            chk($sformatf("sat_cnt5_%0d", p), v, 255);
        end
        hold5 = 1'b0;

        // continuous mode with an ignored start pulse and a mid-window stop
        window_len = 250; period_len = 1000; continuous = 1'b1;
        rises = 0; dones = 0; n = 0; prev = 1'b0;
        start = 1'b1;
        while (n < 4000) begin
            cyc();
            n++;
            if (n == 1) start = 1'b0;
            if (n == 500) start = 1'b1;
            if (n == 501) start = 1'b0;
            if (cal_pulse && !prev && rises < 4) begin
                rise_t[rises] = n;
                rises++;
            end
            prev = cal_pulse;
            if (done) dones++;
            if (rises == 3) continuous = 1'b0;
            if (n > 2 && !busy) break;
        end
        chk("cont_rises", rises, 3);
        chk("cont_first_rise", rise_t[0], 2);
        chk("cont_period_1", rise_t[1] - rise_t[0], 1000);
        chk("cont_period_2", rise_t[2] - rise_t[1], 1000);
        chk("cont_dones", dones, 3);
        chk("cont_stop_time", n, rise_t[2] + 266);
        chk("cont_idle", busy, 0);

        // tolerance band edges and clamping
        pulse0 = 1'b1;
        repeat (4) cyc();
        for (int i = 0; i < 4; i++) begin
            window_len = PW'(wl_t[i]);
            expect_cnt = CW'(ex_t[i]);
            tol = CW'(tol_t[i]);
            launch(wl_t[i], $sformatf("tol%0d", i));
            chk($sformatf("tol%0d_lock0", i), lock[0], lk_t[i]);
            rd(0, 2, v);
            chk($sformatf("tol%0d_cnt", i), v, cnt_t[i]);
        end
        chk("tol_best0", best_phase[1:0], 2);

        // asynchronous reset in the middle of a window
        window_len = 250;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (100) cyc();
        chk("mid_cal_pulse_high", cal_pulse, 1);
        nrst = 1'b0;
        #1;
        chk("mrst_cal_pulse", cal_pulse, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_lock", lock, 0);
        chk("mrst_best", best_phase, 0);
        chk("mrst_rd_data", rd_data, 0);
        chk("mrst_phase", phase, 0);
        pulse0 = 1'b0;
        repeat (2) cyc();
        nrst = 1'b1;
        repeat (3) cyc();
        chk("mrst_idle", busy, 0);
        rd(0, 2, v); chk("mrst_cnt_cleared", v, 0);
        chk("mrst_phase_run", phase, ph_model);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
